// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The master modport is the producer/observer side; slave is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             x_out;
  logic             x_strobe;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  x_out,
    input  x_strobe,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output x_out,
    output x_strobe,
    output busy,
    output done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a word on a valid/ready handshake and
// shifts it out MSB-first, each bit held DIV cycles, with a first-cycle strobe.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bit_serializer_if.slave bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("bit_serializer: DIV must be at least 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("bit_serializer: WIDTH must be at least 2");
  end
  if ($bits(bus.data_in) != WIDTH) begin : g_bad_bus
    $error("bit_serializer: interface WIDTH does not match module WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;

  logic x_out_r;
  logic x_strobe_r;
  logic busy_r;
  logic done_r;
  logic in_ready_r;

  logic             wrap;
  logic             last;
  logic [DCW-1:0]   div_nxt;
  logic [BCW-1:0]   bit_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  // Next-cycle counter/shift values; outputs are registered from these so they
  // line up with the counters they describe.
  always_comb begin
    wrap      = (div_cnt == DIV_LAST);
    last      = wrap && (bit_cnt == BIT_LAST);
    div_nxt   = wrap ? '0 : div_cnt + 1'b1;
    bit_nxt   = wrap ? bit_cnt + 1'b1 : bit_cnt;
    shreg_nxt = wrap ? {shreg[WIDTH-2:0], 1'b0} : shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      x_out_r    <= 1'b0;
      x_strobe_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SHIFT;
            shreg      <= bus.data_in;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            x_out_r    <= bus.data_in[WIDTH-1];
            x_strobe_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (last) begin
            state      <= IDLE;
            shreg      <= shreg_nxt;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            x_out_r    <= 1'b0;
            x_strobe_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
          end else begin
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_nxt;
            div_cnt    <= div_nxt;
            x_out_r    <= shreg_nxt[WIDTH-1];
            x_strobe_r <= wrap;
            busy_r     <= 1'b1;
            // done marks the cycle whose counters will read last bit / last hold
            done_r     <= (bit_nxt == BIT_LAST) && (div_nxt == DIV_LAST);
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out    = x_out_r;
  assign bus.x_strobe = x_strobe_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.in_ready = in_ready_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (DIV=1 and DIV=3) share one stimulus
// stream and are compared every cycle against a time-since-accept model.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] data_in;
  logic         in_valid;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) bus1 ();
  bit_serializer_if #(.WIDTH(W)) bus3 ();

  assign bus1.data_in  = data_in;
  assign bus1.in_valid = in_valid;
  assign bus3.data_in  = data_in;
  assign bus3.in_valid = in_valid;

  bit_serializer #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  bit_serializer #(.WIDTH(W), .DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  logic xo [2];
  logic st [2];
  logic by [2];
  logic dn [2];
  logic rd [2];
  assign xo[0] = bus1.x_out;    assign xo[1] = bus3.x_out;
  assign st[0] = bus1.x_strobe; assign st[1] = bus3.x_strobe;
  assign by[0] = bus1.busy;     assign by[1] = bus3.busy;
  assign dn[0] = bus1.done;     assign dn[1] = bus3.done;
  assign rd[0] = bus1.in_ready; assign rd[1] = bus3.in_ready;

  int tests = 0;
  int fails = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  // Model: t = cycles since the accepting edge (0 means idle), w = accepted word.
  int           t [2] = '{0, 0};
  logic [W-1:0] w [2];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) t[j] = 0;
      else if (t[j] == 0) begin
        if (in_valid) begin
          w[j] = data_in;
          t[j] = 1;
        end
      end else if (t[j] == W * div_of(j)) t[j] = 0;
      else t[j] = t[j] + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 2; j++) begin
        int   d;
        logic act, ex, es, ed;
        d   = div_of(j);
        act = (t[j] != 0);
        ex  = act ? w[j][W - 1 - ((t[j] - 1) / d)] : 1'b0;
        es  = act && (((t[j] - 1) % d) == 0);
        ed  = (t[j] == W * d);
        check_val($sformatf("x_out/div%0d", d),    32'(xo[j]), 32'(ex));
        check_val($sformatf("x_strobe/div%0d", d), 32'(st[j]), 32'(es));
        check_val($sformatf("done/div%0d", d),     32'(dn[j]), 32'(ed));
        check_val($sformatf("busy/div%0d", d),     32'(by[j]), 32'(act));
        check_val($sformatf("in_ready/div%0d", d), 32'(rd[j]), 32'(!act));
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int j = 0; j < 2; j++) begin
      check_val($sformatf("%s x_out/div%0d", tag, div_of(j)),    32'(xo[j]), 32'd0);
      check_val($sformatf("%s x_strobe/div%0d", tag, div_of(j)), 32'(st[j]), 32'd0);
      check_val($sformatf("%s busy/div%0d", tag, div_of(j)),     32'(by[j]), 32'd0);
      check_val($sformatf("%s done/div%0d", tag, div_of(j)),     32'(dn[j]), 32'd0);
      check_val($sformatf("%s in_ready/div%0d", tag, div_of(j)), 32'(rd[j]), 32'd1);
    end
  endtask

  task automatic send(input logic [W-1:0] word);
    @(negedge clk);
    data_in  = word;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    data_in  = '0;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    idle(2);
    #2 rst_n = 1'b1;

    send(8'hB2); idle(30);
    send(8'hA5); idle(30);

    // a word offered mid-stream must wait for in_ready
    send(8'hF0); idle(3);
    data_in  = 8'h0F;
    in_valid = 1'b1;
    idle(4);
    in_valid = 1'b0;
    idle(40);

    // back-to-back words with valid held high
    @(negedge clk);
    data_in  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    data_in  = 8'h00;
    idle(26);
    in_valid = 1'b0;
    idle(60);

    // reset dropped mid-cycle during bit 4 of the DIV=1 stream
    send(8'hFF);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(8'h81); idle(40);

    repeat (400) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      data_in  = W'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
